// File: rtl/uart_tx_scheduler.sv
// Transmit FIFO and frame-paced sequencer feeding the strobe-only uart transmitter.
// Status word exposes drop counter, fill level and busy/full/empty for software polling.
module uart_tx_scheduler #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned BYTE_CYCLES = 10850
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        clr_drop,
    output logic        uart_wr_o,
    output logic [7:0]  uart_dat_o,
    output logic [31:0] status,
    output logic        full,
    output logic        empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(BYTE_CYCLES);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TW-1:0]   r_timer;
    logic [TW-1:0]   w_timer_nxt;
    logic            r_uart_wr;
    logic            w_uart_wr_nxt;
    logic [7:0]      r_uart_dat;
    logic [7:0]      w_uart_dat_nxt;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [7:0]      r_drop_cnt;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_busy;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en && !w_full;
    assign w_drop  = wr_en && w_full;
    assign w_busy  = (r_state == S_WAIT) || !w_empty;

    // Scheduler state, frame timer and registered uart outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_timer    <= '0;
            r_uart_wr  <= 1'b0;
            r_uart_dat <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_uart_wr  <= w_uart_wr_nxt;
            r_uart_dat <= w_uart_dat_nxt;
        end
    end

    // Issue only from IDLE, so pushes into an empty FIFO are never bypassed
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_uart_wr_nxt  = 1'b0;
        w_uart_dat_nxt = r_uart_dat;
        w_pop          = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_uart_wr_nxt  = 1'b1;
                    w_uart_dat_nxt = r_mem[r_rd_ptr];
                    w_pop          = 1'b1;
                    w_timer_nxt    = TW'(BYTE_CYCLES - 1);
                    w_state_nxt    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_timer == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - TW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FIFO pointers and fill level; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    // Saturating drop counter; a drop on the clear edge still counts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= 8'h00;
        end else if (clr_drop) begin
            r_drop_cnt <= w_drop ? 8'h01 : 8'h00;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'h01;
        end
    end

    assign uart_wr_o  = r_uart_wr;
    assign uart_dat_o = r_uart_dat;
    assign full       = w_full;
    assign empty      = w_empty;
    assign status     = {8'h00, r_drop_cnt, 8'(r_count), 5'b0_0000, w_busy, w_full, w_empty};

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with DEPTH=4, BYTE_CYCLES=4.
module tb_uart_tx_scheduler;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [7:0]  wr_data;
    logic        clr_drop;
    logic        uart_wr_o;
    logic [7:0]  uart_dat_o;
    logic [31:0] status;
    logic        full;
    logic        empty;

    int n_cmp;
    int n_err;
    int pos [8];
    logic [7:0] dat [8];
    logic emp [8];
    int ns;

    uart_tx_scheduler #(.DEPTH(4), .BYTE_CYCLES(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .clr_drop   (clr_drop),
        .uart_wr_o  (uart_wr_o),
        .uart_dat_o (uart_dat_o),
        .status     (status),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rec();
        ns = 0;
        for (int k = 0; k < 8; k++) begin
            pos[k] = -1;
            dat[k] = 8'h00;
            emp[k] = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int c = 0; c < 6; c++) begin
            wr_en   = c[0];
            wr_data = 8'(32'h90 + c);
            tick();
            n_cmp++;
            if (status !== 32'h0000_0001) begin
                n_err++;
                $display("FAIL reset_status cyc=%0d got=%h want=00000001", c, status);
            end
            n_cmp++;
            if (uart_wr_o !== 1'b0) begin
                n_err++;
                $display("FAIL reset_strobe cyc=%0d got=%b want=0", c, uart_wr_o);
            end
        end
        n_cmp++;
        if (uart_dat_o !== 8'h00) begin
            n_err++;
            $display("FAIL reset_dat got=%h want=00", uart_dat_o);
        end
        wr_en = 1'b0;
        rst_n = 1'b1;
        ns = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (uart_wr_o) ns++;
        end
        n_cmp++;
        if (ns !== 0) begin
            n_err++;
            $display("FAIL reset_no_push_strobe got=%0d want=0", ns);
        end
    endtask

    task automatic test_single();
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if ({uart_wr_o, empty, status[2]} !== 3'b001) begin
            n_err++;
            $display("FAIL single_after_push wr/empty/busy got=%b want=001", {uart_wr_o, empty, status[2]});
        end
        tick();
        n_cmp++;
        if (uart_wr_o !== 1'b1 || uart_dat_o !== 8'hA5) begin
            n_err++;
            $display("FAIL single_strobe got wr=%b dat=%h want wr=1 dat=a5", uart_wr_o, uart_dat_o);
        end
        n_cmp++;
        if (empty !== 1'b1 || status[2] !== 1'b1) begin
            n_err++;
            $display("FAIL single_issue_flags got empty=%b busy=%b want 1 1", empty, status[2]);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (uart_wr_o !== 1'b0 || status[2] !== 1'b1) begin
                n_err++;
                $display("FAIL single_wait cyc=%0d got wr=%b busy=%b want 0 1", c, uart_wr_o, status[2]);
            end
        end
        tick();
        n_cmp++;
        if (status !== 32'h0000_0001 || uart_dat_o !== 8'hA5) begin
            n_err++;
            $display("FAIL single_idle got status=%h dat=%h want 00000001 a5", status, uart_dat_o);
        end
        tick();
        tick();
    endtask

    task automatic test_burst();
        clear_rec();
        for (int c = 0; c < 30; c++) begin
            wr_en   = (c < 3);
            wr_data = (c == 0) ? 8'h11 : (c == 1) ? 8'h22 : 8'h33;
            tick();
            if (uart_wr_o) begin
                if (ns < 8) begin
                    pos[ns] = c;
                    dat[ns] = uart_dat_o;
                    emp[ns] = empty;
                end
                ns++;
            end
        end
        wr_en = 1'b0;
        n_cmp++;
        if (ns !== 3) begin
            n_err++;
            $display("FAIL burst_count got=%0d want=3", ns);
        end
        n_cmp++;
        if (pos[0] !== 1 || pos[1] - pos[0] !== 5 || pos[2] - pos[1] !== 5) begin
            n_err++;
            $display("FAIL burst_spacing got=%0d,%0d,%0d want=1,6,11", pos[0], pos[1], pos[2]);
        end
        n_cmp++;
        if (dat[0] !== 8'h11 || dat[1] !== 8'h22 || dat[2] !== 8'h33) begin
            n_err++;
            $display("FAIL burst_order got=%h,%h,%h want=11,22,33", dat[0], dat[1], dat[2]);
        end
        n_cmp++;
        if (emp[1] !== 1'b0 || emp[2] !== 1'b1) begin
            n_err++;
            $display("FAIL burst_empty got=%b,%b want=0,1", emp[1], emp[2]);
        end
    endtask

    task automatic test_overflow();
        clear_rec();
        for (int c = 0; c < 30; c++) begin
            wr_en   = (c < 6);
            wr_data = 8'(32'h40 + c);
            tick();
            if (c == 4) begin
                n_cmp++;
                if (status[15:8] !== 8'd4 || full !== 1'b1) begin
                    n_err++;
                    $display("FAIL ovf_full got count=%0d full=%b want 4 1", status[15:8], full);
                end
            end
            if (c == 5) begin
                n_cmp++;
                if (status[23:16] !== 8'd1 || status[15:8] !== 8'd4) begin
                    n_err++;
                    $display("FAIL ovf_drop got drop=%0d count=%0d want 1 4", status[23:16], status[15:8]);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (status[15:8] !== 8'd3) begin
                    n_err++;
                    $display("FAIL ovf_drain got count=%0d want 3", status[15:8]);
                end
            end
            if (uart_wr_o) begin
                if (ns < 8) begin
                    pos[ns] = c;
                    dat[ns] = uart_dat_o;
                end
                ns++;
            end
        end
        wr_en = 1'b0;
        n_cmp++;
        if (ns !== 5) begin
            n_err++;
            $display("FAIL ovf_issued got=%0d want=5", ns);
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (pos[k] !== 1 + 5 * k || dat[k] !== 8'(32'h40 + k)) begin
                n_err++;
                $display("FAIL ovf_seq k=%0d got cyc=%0d dat=%h want cyc=%0d dat=%h",
                         k, pos[k], dat[k], 1 + 5 * k, 8'(32'h40 + k));
            end
        end
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        n_cmp++;
        if (status !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL ovf_clr got status=%h want 00000001", status);
        end
    endtask

    task automatic test_full_pop_collision();
        clear_rec();
        for (int c = 0; c < 30; c++) begin
            wr_en   = (c < 5) || (c == 6);
            wr_data = (c == 6) ? 8'hEE : 8'(32'h50 + c);
            tick();
            if (c == 5) begin
                n_cmp++;
                if (full !== 1'b1 || status[23:16] !== 8'd0) begin
                    n_err++;
                    $display("FAIL coll_pre got full=%b drop=%0d want 1 0", full, status[23:16]);
                end
            end
            if (c == 6) begin
                n_cmp++;
                if (status[15:8] !== 8'd3 || status[23:16] !== 8'd1 || uart_wr_o !== 1'b1) begin
                    n_err++;
                    $display("FAIL coll_edge got count=%0d drop=%0d wr=%b want 3 1 1",
                             status[15:8], status[23:16], uart_wr_o);
                end
            end
            if (uart_wr_o) begin
                if (ns < 8) begin
                    pos[ns] = c;
                    dat[ns] = uart_dat_o;
                end
                ns++;
            end
        end
        wr_en = 1'b0;
        n_cmp++;
        if (ns !== 5) begin
            n_err++;
            $display("FAIL coll_issued got=%0d want=5", ns);
        end
        for (int k = 0; k < 5; k++) begin
            n_cmp++;
            if (pos[k] !== 1 + 5 * k || dat[k] !== 8'(32'h50 + k)) begin
                n_err++;
                $display("FAIL coll_seq k=%0d got cyc=%0d dat=%h want cyc=%0d dat=%h",
                         k, pos[k], dat[k], 1 + 5 * k, 8'(32'h50 + k));
            end
        end
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
    endtask

    task automatic test_drop_saturate();
        for (int c = 0; c < 400; c++) begin
            wr_en   = 1'b1;
            wr_data = 8'(c);
            tick();
        end
        n_cmp++;
        if (status[23:16] !== 8'hFF) begin
            n_err++;
            $display("FAIL sat_drop got=%0d want=255", status[23:16]);
        end
        if (uart_wr_o) tick();
        n_cmp++;
        if (full !== 1'b1) begin
            n_err++;
            $display("FAIL sat_full got=%b want=1", full);
        end
        clr_drop = 1'b1;
        tick();
        n_cmp++;
        if (status[23:16] !== 8'd1) begin
            n_err++;
            $display("FAIL clr_with_drop got=%0d want=1", status[23:16]);
        end
        wr_en = 1'b0;
        tick();
        clr_drop = 1'b0;
        n_cmp++;
        if (status[23:16] !== 8'd0) begin
            n_err++;
            $display("FAIL clr_plain got=%0d want=0", status[23:16]);
        end
        for (int c = 0; c < 60 && status[2] !== 1'b0; c++) tick();
        n_cmp++;
        if (status !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL sat_drain got status=%h want 00000001", status);
        end
    endtask

    task automatic test_reset_mid();
        for (int c = 0; c < 4; c++) begin
            wr_en   = 1'b1;
            wr_data = 8'(32'h60 + c);
            tick();
        end
        wr_en = 1'b0;
        n_cmp++;
        if (status[15:8] !== 8'd3 || status[2] !== 1'b1) begin
            n_err++;
            $display("FAIL rmid_pre got count=%0d busy=%b want 3 1", status[15:8], status[2]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (status !== 32'h0000_0001 || uart_wr_o !== 1'b0 || uart_dat_o !== 8'h00) begin
            n_err++;
            $display("FAIL rmid_async got status=%h wr=%b dat=%h want 00000001 0 00", status, uart_wr_o, uart_dat_o);
        end
        tick();
        rst_n = 1'b1;
        ns = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (uart_wr_o) ns++;
        end
        n_cmp++;
        if (ns !== 0 || status !== 32'h0000_0001) begin
            n_err++;
            $display("FAIL rmid_discard got strobes=%0d status=%h want 0 00000001", ns, status);
        end
        wr_en   = 1'b1;
        wr_data = 8'h7E;
        tick();
        wr_en = 1'b0;
        n_cmp++;
        if (empty !== 1'b0 || uart_wr_o !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_push got empty=%b wr=%b want 0 0", empty, uart_wr_o);
        end
        tick();
        n_cmp++;
        if (uart_wr_o !== 1'b1 || uart_dat_o !== 8'h7E) begin
            n_err++;
            $display("FAIL rmid_strobe got wr=%b dat=%h want 1 7e", uart_wr_o, uart_dat_o);
        end
        for (int c = 0; c < 8; c++) tick();
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 8'h00;
        clr_drop = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_full_pop_collision();
        test_drop_saturate();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Transmit buffer and sequencer between the CPU memory-access stage and the `uart` transmitter. CPU stores to `UART_ADDR` push bytes into a FIFO without stalling. The scheduler issues one byte at a time to `uart`, spacing the write strobes by a fixed frame time, because `uart` has no busy output. A status word is exposed for software polling through the load-data mux, alongside the hardware counter.

## Interface

Parameters:
- `DEPTH`, 16: FIFO entries; power of 2, ≥2.
- `BYTE_CYCLES`, 10850: clk cycles one UART frame occupies (10 bits × clk/baud); ≥2.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: push request; CPU store to `UART_ADDR`.
- `wr_data` in 8: byte to push; store data [7:0].
- `clr_drop` in 1: synchronous clear of drop counter.
- `uart_wr_o` out 1: one-cycle write strobe to `uart.uart_wr_i`.
- `uart_dat_o` out 8: byte to `uart.uart_dat_i`; held until next strobe.
- `status` out 32: {8'h0, drop_cnt[7:0], 3'b0, count[4:0], 5'b0, busy, full, empty}. The layout is shown for `DEPTH`=16; count width is clog2(DEPTH)+1.
- `full` out 1: count == `DEPTH`.
- `empty` out 1: count == 0.

## Operation

FIFO:
- Circular buffer with `rd_ptr`/`wr_ptr` of clog2(DEPTH) bits that wrap modulo `DEPTH`, plus a separate `count`.
- Push occurs when `wr_en` && !`full`. `full` is the pre-edge value, so a push arriving while full is rejected even if a pop happens on the same edge.
- A rejected push increments `drop_cnt`, which saturates at 255.
- `clr_drop` zeroes `drop_cnt`. If a drop occurs on the same edge, the result is 1.
- Simultaneous push and pop with 0 < count < `DEPTH`: count unchanged, both pointers advance.

Scheduler FSM (states IDLE, WAIT):
- **IDLE**, !`empty`: on the edge, `uart_wr_o`<=1, `uart_dat_o`<=mem[rd_ptr], pop, `timer`<=`BYTE_CYCLES`-1, go to WAIT.
- **IDLE**, `empty`: `uart_wr_o`<=0, stay in IDLE.
- **WAIT**: `uart_wr_o`<=0. If `timer`==0, go to IDLE; otherwise `timer`<=`timer`-1.
- `busy` = (state==WAIT) || !`empty`.
- A push into an empty FIFO while in IDLE is not bypassed. The byte is written first and issued on the following edge.
- Bytes leave in strict push order. No byte is issued twice or skipped.

Reset (async, `rst_n`=0):
- state IDLE; `rd_ptr`, `wr_ptr`, `count`, `timer`, `drop_cnt` = 0.
- `uart_wr_o`=0, `uart_dat_o`=8'h00, `empty`=1, `full`=0, `status`=32'h0000_0001.
- Reset mid-frame discards all queued bytes and the in-flight timer. No strobe occurs while `rst_n`=0.

## Timing

- All outputs are registered or decoded from registers only. There is no combinational path from `wr_en` to any output.
- Latency, idle and empty: `wr_en` sampled at edge E → `empty` falls after E → `uart_wr_o` is high for exactly the cycle after E+1 with `uart_dat_o`=`wr_data`.
- Strobe spacing with a backlog: consecutive `uart_wr_o` rising edges are exactly `BYTE_CYCLES`+1 cycles apart.
- `uart_wr_o` is never high for two consecutive cycles.
- `full`/`empty`/`count` reflect the post-edge state in the cycle after a push or pop.
- Memory array needs no reset. The read is registered into `uart_dat_o` at the issue edge.

## Test plan

All scenarios use `DEPTH`=4, `BYTE_CYCLES`=4.

1. **Reset:** hold `rst_n`=0, toggle `wr_en` → `status`=32'h0000_0001, `uart_wr_o`=0 throughout; after release, first strobe only follows a push.
2. **Single byte:** push 8'hA5 at edge E → `uart_wr_o` high for one cycle after E+1 with `uart_dat_o`=8'hA5; `busy` stays 1 for 4 further cycles, then 0.
3. **Burst:** push 8'h11, 8'h22, 8'h33 on three consecutive edges → three strobes, rising edges 5 cycles apart, data 11, 22, 33 in order; `empty` returns to 1 after the third issue.
4. **Overflow:** push 6 bytes on consecutive edges from idle → the first byte is issued, 4 are queued, 1 is dropped (`drop_cnt`=1). `status`[13:8] shows count=4 then decreases. Then pulse `clr_drop` → `drop_cnt`=0.
5. **Full + pop collision:** with FIFO full and the issue edge coinciding with `wr_en` → push rejected, `drop_cnt` increments, count goes to 3.
6. **Reset mid-operation:** assert `rst_n`=0 for one cycle during WAIT with 3 bytes queued → no further strobes, `status`=32'h0000_0001. A new push is then issued with standard latency.
